// File: rtl/hex_mem_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ event-writer requesters into one host memory write port.
// Each grant allows up to BURST_MAX beats. A frame counter counts completed host beats.
module hex_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][63:0] req_data,
  output logic [31:0]              mem_addr,
  output logic [63:0]              mem_data,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic [31:0]              frame_beats
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic [IDX_W-1:0] last_grant, last_next;
  logic [IDX_W-1:0] winner, cand;
  logic [7:0]       burst_cnt, burst_next;
  logic             found, accept, grant_end, mem_done;

  assign mem_done = mem_we && mem_ready;
  assign grant_id = 3'(owner);
  assign busy     = (state == GRANT) || mem_we;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    winner = last_grant;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    last_next  = last_grant;
    burst_next = burst_cnt;
    req_ready  = '0;
    accept     = 1'b0;
    grant_end  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          owner_next = winner;
          state_next = GRANT;
        end
      end
      GRANT: begin
        req_ready[owner] = !mem_we || mem_ready;
        accept = req_valid[owner] && req_ready[owner];
        if (accept) begin
          burst_next = burst_cnt + 8'd1;
        end
        // The output beat register drains on its own after the grant is released.
        grant_end = !req_valid[owner] ||
                    (accept && (burst_cnt == 8'(BURST_MAX - 1)));
        if (grant_end) begin
          state_next = IDLE;
          last_next  = owner;
          burst_next = 8'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= 8'd0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_grant <= last_next;
      burst_cnt  <= burst_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_data    <= 64'd0;
      frame_beats <= 32'd0;
    end else begin
      if (accept) begin
        mem_addr <= req_addr[owner];
        mem_data <= req_data[owner];
        mem_we   <= 1'b1;
      end else if (mem_done) begin
        mem_we <= 1'b0;
      end
      if (frame_start) begin
        frame_beats <= mem_done ? 32'd1 : 32'd0;
      end else if (mem_done) begin
        frame_beats <= frame_beats + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hex_mem_arbiter.sv
// Self-checking bench for hex_mem_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of grants, beats and the frame counter.
module tb_hex_mem_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BURST_MAX = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     frame_start;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][63:0] req_data;
  logic [31:0]              mem_addr;
  logic [63:0]              mem_data;
  logic                     mem_we;
  logic                     mem_ready;
  logic [2:0]               grant_id;
  logic                     busy;
  logic [31:0]              frame_beats;

  int checks = 0;
  int errors = 0;

  // Reference model state: owner is -1 when nobody holds the port.
  int          owner;
  int          last_owner;
  int          burst;
  bit          out_v;
  logic [31:0] out_a;
  logic [63:0] out_d;
  logic [31:0] frame;
  int          seq      [NUM_REQ];
  logic [63:0] cur_data [NUM_REQ];
  logic [NUM_REQ-1:0] active;

  hex_mem_arbiter #(.NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ready(mem_ready), .grant_id(grant_id), .busy(busy),
    .frame_beats(frame_beats)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    owner      = -1;
    last_owner = NUM_REQ - 1;
    burst      = 0;
    out_v      = 1'b0;
    out_a      = 32'd0;
    out_d      = 64'd0;
    frame      = 32'd0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic applyStimulus(input logic rst, input logic fs,
                               input logic [NUM_REQ-1:0] vmask, input logic mr);
    logic [NUM_REQ-1:0] exp_ready;
    bit complete, acc, found;
    int c;
    checkOutput("mem_we", mem_we, out_v);
    checkOutput("mem_addr", mem_addr, out_a);
    checkOutput("mem_data", mem_data, out_d);
    checkOutput("busy", busy, (owner >= 0) || out_v);
    if (owner >= 0) checkOutput("grant_id", grant_id, 3'(owner));
    checkOutput("frame_beats", frame_beats, frame);

    reset       = rst;
    frame_start = fs;
    mem_ready   = mr;
    req_valid   = vmask;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_addr[r] = {4'(r), 28'(seq[r])};
      req_data[r] = cur_data[r];
    end
    #1;
    exp_ready = '0;
    if (owner >= 0 && (!out_v || mr)) exp_ready[owner] = 1'b1;
    checkOutput("req_ready", req_ready, exp_ready);

    complete = out_v && mr;
    if (rst) begin
      modelReset();
    end else begin
      if (fs) frame = complete ? 32'd1 : 32'd0;
      else if (complete) frame = frame + 32'd1;
      if (owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (last_owner + k) % NUM_REQ;
          if (!found && vmask[c]) begin
            owner = c;
            found = 1'b1;
          end
        end
        if (complete) out_v = 1'b0;
      end else begin
        acc = vmask[owner] && (!out_v || mr);
        if (acc) begin
          out_a = {4'(owner), 28'(seq[owner])};
          out_d = cur_data[owner];
          out_v = 1'b1;
          burst++;
          seq[owner]++;
          cur_data[owner] = {$urandom, $urandom};
        end else if (complete) begin
          out_v = 1'b0;
        end
        if ((acc && burst == BURST_MAX) || !vmask[owner]) begin
          last_owner = owner;
          owner      = -1;
          burst      = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    mem_ready   = 1'b0;
    req_valid   = '0;
    active      = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      seq[r]      = 0;
      cur_data[r] = {$urandom, $urandom};
      req_addr[r] = '0;
      req_data[r] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame", frame_beats, 0);
    checkOutput("rst_grant", grant_id, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_addr", mem_addr, 0);

    // Requesters 0 and 2 compete: two full bursts separated by one idle cycle.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 4'b0101, 1'b1);
    checkOutput("two_bursts_frame", frame_beats, 16);

    // Requester 1 sends three beats then drops; next winner must be requester 2.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'b0010, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    checkOutput("short_frame", frame_beats, 3);
    checkOutput("short_busy", busy, 0);
    applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);
    checkOutput("after_last1_grant", grant_id, 2);

    // Host stall for five cycles, completion, then reset during a second stall.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0001, 1'b1);
    checkOutput("stall_done_frame", frame_beats, 1);
    applyStimulus(1'b0, 1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0001, 1'b0);
    checkOutput("midrst_mem_we", mem_we, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_frame", frame_beats, 0);
    checkOutput("midrst_ready", req_ready, 0);

    // frame_start coincident with a completing beat.
    for (int i = 0; i < 50 && !(frame == 32'd10 && out_v); i++)
      applyStimulus(1'b0, 1'b0, 4'b0001, 1'b1);
    checkOutput("fs_pre_frame", frame_beats, 10);
    applyStimulus(1'b0, 1'b1, 4'b0001, 1'b1);
    checkOutput("fs_frame", frame_beats, 1);
    checkOutput("fs_grant", grant_id, 0);

    // All requesters busy: rotation 0,1,2,3,0.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 5 * (BURST_MAX + 1); i++) applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);

    // Randomized traffic with host backpressure, frame pulses and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if ($urandom_range(7) == 0) active[r] = ~active[r];
      applyStimulus($urandom_range(399) == 0, $urandom_range(15) == 0,
                    active, $urandom_range(3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_mem_arbiter.md
HEX_MEM_ARBITER -- requirements
Module: hex_mem_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of event-writer requesters (2..8).
REQ-002 SHALL have parameter: BURST_MAX, 8, maximum beats accepted per grant (1..255).
REQ-003 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: frame_start  input  1  one-cycle pulse; clears frame beat counter.
REQ-006 SHALL have port: req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port: req_ready  output  NUM_REQ  per-requester beat accept.
REQ-008 SHALL have port: req_addr  input  NUM_REQ x 32  per-requester write address.
REQ-009 SHALL have port: req_data  input  NUM_REQ x 64  per-requester write data.
REQ-010 SHALL have port: mem_addr  output  32  host memory address.
REQ-011 SHALL have port: mem_data  output  64  host memory write data.
REQ-012 SHALL have port: mem_we  output  1  host write strobe; beat valid.
REQ-013 SHALL have port: mem_ready  input  1  host accepts beat when mem_we && mem_ready.
REQ-014 SHALL have port: grant_id  output  3  index of current owner; meaningful only when busy.
REQ-015 SHALL have port: busy  output  1  high in GRANT state or while mem_we is high.
REQ-016 SHALL have port: frame_beats  output  32  host beats completed since last frame_start/reset.

Function
REQ-017 SHALL implement FSM states IDLE and GRANT.
REQ-018 IDLE: if any req_valid is high, SHALL select the winner round-robin, starting the search at (last_grant+1) mod NUM_REQ, load grant_id, and enter GRANT the next cycle; req_ready SHALL be all-zero in IDLE.
REQ-019 Arbitration latency SHALL be one cycle from req_valid rising in IDLE to the first cycle req_ready can be high.
REQ-020 GRANT: req_ready[grant_id] SHALL equal (!mem_we || mem_ready); all other req_ready bits SHALL be 0.
REQ-021 A requester beat is accepted when req_valid[g] && req_ready[g]; on acceptance, mem_addr/mem_data SHALL load req_addr[g]/req_data[g] and mem_we SHALL be 1 the next cycle.
REQ-022 mem_addr, mem_data, mem_we SHALL be held stable while mem_we && !mem_ready.
REQ-023 On mem_we && mem_ready with no new acceptance in the same cycle, mem_we SHALL clear the next cycle; with a simultaneous acceptance, the new beat SHALL load back-to-back (full throughput, one beat/cycle).
REQ-024 An 8-bit burst counter SHALL count accepted beats per grant; the grant SHALL end after the beat that makes the count equal to BURST_MAX, or on any cycle in GRANT where req_valid[grant_id] is low.
REQ-025 On grant end, the FSM SHALL return to IDLE, record last_grant = grant_id, and clear the burst counter; the in-flight output beat SHALL drain independently.
REQ-026 With a single active requester, re-grant after BURST_MAX SHALL cost exactly one IDLE cycle.
REQ-027 frame_beats SHALL increment by 1 on every mem_we && mem_ready, wrapping at 2^32.
REQ-028 frame_start SHALL set frame_beats to 0, or to 1 if a host beat completes in the same cycle; frame_start SHALL NOT affect FSM, grant, or in-flight beats.
REQ-029 req_addr/req_data of non-granted requesters SHALL be ignored; requester order SHALL be preserved per requester (no reordering within a requester).

Reset
REQ-030 On reset: state IDLE, mem_we 0, mem_addr 0, mem_data 0, req_ready 0, grant_id 0, busy 0, frame_beats 0, burst counter 0, last_grant NUM_REQ-1 (so requester 0 wins first).
REQ-031 Reset mid-operation SHALL drop any held output beat without completing it; reset SHALL dominate frame_start and all requests.

Verification
REQ-032 Req 0 and 2 valid from reset, mem_ready=1, BURST_MAX=8 -> req 0 gets 8 beats at one beat/cycle, one IDLE cycle, then req 2 gets 8; frame_beats=16.
REQ-033 Req 1 only, 3 beats then valid drops, mem_ready=1 -> grant ends after beat 3, FSM IDLE, frame_beats=3, last_grant=1.
REQ-034 Req 0 valid, mem_ready held 0 for 5 cycles -> mem_we=1 with addr/data unchanged for 5 cycles, req_ready[0]=0 throughout, beat completes when mem_ready rises.
REQ-035 frame_beats=10, frame_start pulse coincident with completed beat -> frame_beats=1 next cycle; grant unaffected.
REQ-036 All four requesters valid continuously -> grant order 0,1,2,3,0 with BURST_MAX beats each; no requester starved.
REQ-037 Reset asserted while mem_we=1 and mem_ready=0 -> next cycle mem_we=0, req_ready=0, frame_beats=0, state IDLE.
